// File: rtl/quarter_period_meter.sv
// Measures the period of an asynchronous reference in sclock cycles and publishes period/4.
// Optional input glitch filter is enabled by defining QPM_GLITCH_FILTER_EN.
module quarter_period_meter #(
   parameter int          QP_WIDTH       = 16,
   parameter int          MIN_PERIOD     = 4,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
   input  logic                sclock,
   input  logic                reset,
   input  logic                sig_in,
   output logic [QP_WIDTH-1:0] count_quarter_period,
   output logic                rt,
   output logic                valid,
   output logic                saturated,
   output logic                timeout,
   output logic                glitch
);

   typedef enum logic {IDLE, MEASURE} state_t;

   localparam logic [32:0] QP_MAX = (33'd1 << QP_WIDTH) - 33'd1;

   function automatic logic qp_over(input logic [31:0] q);
      return {1'b0, q} > QP_MAX;
   endfunction

   function automatic logic [QP_WIDTH-1:0] qp_sat(input logic [31:0] q);
      if (qp_over(q)) return '1;
      else            return q[QP_WIDTH-1:0];
   endfunction

   logic                sync1_q, sync2_q;
   logic                lvl;
   logic                lvl_prev_q, edge_q;
   state_t              state_q, state_d;
   logic [31:0]         period_cnt_q, period_cnt_d;
   logic [31:0]         quarter;
   logic [QP_WIDTH-1:0] count_q, count_d;
   logic                sat_q, sat_d;
   logic                valid_q, valid_d;
   logic                rt_q, rt_d;
   logic                timeout_q, timeout_d;
   logic                glitch_q, glitch_d;

   always_ff @(posedge sclock) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= sig_in;
         sync2_q <= sync1_q;
      end
   end

`ifdef QPM_GLITCH_FILTER_EN
   // The filtered level follows sync2 once it has differed for three cycles in a row.
   logic       flt_q, flt_d;
   logic [1:0] run_q, run_d;

   always_comb begin
      flt_d = flt_q;
      run_d = 2'd0;
      if (sync2_q != flt_q) begin
         if (run_q == 2'd2) flt_d = sync2_q;
         else               run_d = run_q + 2'd1;
      end
   end

   always_ff @(posedge sclock) begin
      if (reset) begin
         flt_q <= 1'b0;
         run_q <= 2'd0;
      end else begin
         flt_q <= flt_d;
         run_q <= run_d;
      end
   end

   assign lvl = flt_d;
`else
   assign lvl = sync2_q;
`endif

   always_ff @(posedge sclock) begin
      if (reset) begin
         lvl_prev_q <= 1'b0;
         edge_q     <= 1'b0;
      end else begin
         lvl_prev_q <= lvl;
         edge_q     <= lvl & ~lvl_prev_q;
      end
   end

   always_ff @(posedge sclock) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (edge_q) state_d = MEASURE;
         MEASURE: if (!edge_q && period_cnt_q == TIMEOUT_CYCLES) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign quarter = period_cnt_q >> 2;

   // An edge always wins over a coincident timeout.
   always_comb begin
      period_cnt_d = period_cnt_q;
      count_d      = count_q;
      sat_d        = sat_q;
      valid_d      = valid_q;
      rt_d         = 1'b0;
      timeout_d    = 1'b0;
      glitch_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (edge_q) period_cnt_d = 32'd1;
         end
         MEASURE: begin
            if (edge_q) begin
               period_cnt_d = 32'd1;
               if (period_cnt_q < 32'(MIN_PERIOD)) begin
                  glitch_d = 1'b1;
               end else begin
                  rt_d    = 1'b1;
                  valid_d = 1'b1;
                  count_d = qp_sat(quarter);
                  sat_d   = qp_over(quarter);
               end
            end else if (period_cnt_q == TIMEOUT_CYCLES) begin
               timeout_d    = 1'b1;
               valid_d      = 1'b0;
               period_cnt_d = 32'd0;
            end else begin
               period_cnt_d = period_cnt_q + 32'd1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge sclock) begin
      if (reset) begin
         period_cnt_q <= 32'd0;
         count_q      <= '0;
         sat_q        <= 1'b0;
         valid_q      <= 1'b0;
         rt_q         <= 1'b0;
         timeout_q    <= 1'b0;
         glitch_q     <= 1'b0;
      end else begin
         period_cnt_q <= period_cnt_d;
         count_q      <= count_d;
         sat_q        <= sat_d;
         valid_q      <= valid_d;
         rt_q         <= rt_d;
         timeout_q    <= timeout_d;
         glitch_q     <= glitch_d;
      end
   end

   assign count_quarter_period = count_q;
   assign saturated            = sat_q;
   assign valid                = valid_q;
   assign rt                   = rt_q;
   assign timeout              = timeout_q;
   assign glitch               = glitch_q;

endmodule

// File: tb/tb_quarter_period_meter.sv
// Scoreboard bench for quarter_period_meter (QP_WIDTH=8, TIMEOUT_CYCLES=3000, default build).
module tb_quarter_period_meter;

   localparam int QPW = 8;
   localparam int MINP = 4;
   localparam int TMO = 3000;

   logic           sclock = 1'b0;
   logic           reset;
   logic           sig_in;
   logic [QPW-1:0] count_quarter_period;
   logic           rt, valid, saturated, timeout, glitch;

   quarter_period_meter #(
      .QP_WIDTH      (QPW),
      .MIN_PERIOD    (MINP),
      .TIMEOUT_CYCLES(32'(TMO))
   ) dut (
      .sclock              (sclock),
      .reset               (reset),
      .sig_in              (sig_in),
      .count_quarter_period(count_quarter_period),
      .rt                  (rt),
      .valid               (valid),
      .saturated           (saturated),
      .timeout             (timeout),
      .glitch              (glitch)
   );

   always #5 sclock = ~sclock;

   typedef struct {
      int kind;   // 0 rt, 1 glitch, 2 timeout
      int cnt;
      int sat;
      int vld;
   } ev_t;

   ev_t sb[$];
   int  checks = 0;
   int  errors = 0;
   bit  mon_en = 1'b0;

   int  armed = 0;
   int  cyc_since_rise = 0;
   int  exp_count = 0;
   int  exp_sat = 0;
   int  exp_valid = 0;

   task automatic chk(input string tag, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic push(input int kind);
      ev_t e;
      e.kind = kind;
      e.cnt  = exp_count;
      e.sat  = exp_sat;
      e.vld  = exp_valid;
      sb.push_back(e);
   endtask

   task automatic model_rise();
      int q;
      if (armed == 0) begin
         armed = 1;
      end else if (cyc_since_rise < MINP) begin
         push(1);
      end else begin
         q = cyc_since_rise / 4;
         if (q > (1 << QPW) - 1) begin
            exp_count = (1 << QPW) - 1;
            exp_sat   = 1;
         end else begin
            exp_count = q;
            exp_sat   = 0;
         end
         exp_valid = 1;
         push(0);
      end
      cyc_since_rise = 0;
   endtask

   task automatic tick();
      @(posedge sclock);
      #1;
      cyc_since_rise++;
      if (armed != 0 && cyc_since_rise == TMO + 1) begin
         exp_valid = 0;
         push(2);
         armed = 0;
      end
   endtask

   task automatic pulse_after(input int n);
      int h;
      h = (n / 2 < 1) ? 1 : n / 2;
      model_rise();
      sig_in = 1'b1;
      repeat (h) tick();
      sig_in = 1'b0;
      repeat (n - h) tick();
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_cnt"}, int'(count_quarter_period), 0);
      chk({tag, "_rt"}, int'(rt), 0);
      chk({tag, "_valid"}, int'(valid), 0);
      chk({tag, "_sat"}, int'(saturated), 0);
      chk({tag, "_timeout"}, int'(timeout), 0);
      chk({tag, "_glitch"}, int'(glitch), 0);
   endtask

   always @(negedge sclock) begin
      if (mon_en && (rt || glitch || timeout)) begin
         ev_t e;
         chk("excl", int'(rt) + int'(glitch) + int'(timeout), 1);
         if (sb.size() == 0) begin
            chk("unexpected_strobe", int'({timeout, glitch, rt}), 0);
         end else begin
            e = sb.pop_front();
            chk("kind", rt ? 0 : (glitch ? 1 : 2), e.kind);
            chk("count", int'(count_quarter_period), e.cnt);
            chk("sat", int'(saturated), e.sat);
            chk("valid", int'(valid), e.vld);
         end
      end
   end

   int periods_a[] = '{400, 400, 400, 400, 401, 403, 2000, 400, 400, 3, 400, 3000, 400, 400};

   initial begin
      reset  = 1'b1;
      sig_in = 1'b0;
      repeat (3) @(posedge sclock);
      #1;
      chk_zero("reset");
      reset = 1'b0;
      mon_en = 1'b1;
      repeat (2) tick();
      cyc_since_rise = 0;

      foreach (periods_a[i]) pulse_after(periods_a[i]);

      // signal stops: expect a single timeout with the value held
      repeat (TMO + 500) tick();
      chk("after_timeout_valid", int'(valid), 0);
      chk("after_timeout_cnt", int'(count_quarter_period), exp_count);
      repeat (3) pulse_after(400);

      // reset 200 cycles into a period
      model_rise();
      sig_in = 1'b1;
      repeat (100) tick();
      sig_in = 1'b0;
      repeat (100) tick();
      reset = 1'b1;
      @(posedge sclock);
      #1;
      reset = 1'b0;
      chk_zero("midreset");
      armed = 0;
      cyc_since_rise = 0;
      exp_count = 0;
      exp_sat = 0;
      exp_valid = 0;
      repeat (5) tick();
      repeat (3) pulse_after(400);

      repeat (20) tick();
      chk("drain", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
